cdb_arb_2x1: RTL and testbench

CDB_ARB_2X1 -- requirements
Module: cdb_arb_2x1

---
 rtl/cdb_arb_2x1.sv | 90 +++++++++
 tb/tb_cdb_arb_2x1.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arb_2x1.sv
// Two-requester round-robin arbiter feeding a single registered common-data-bus slot.
// One transfer per cycle is sustained when the consumer keeps out_ready high.
module cdb_arb_2x1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             out_src,
  output logic [7:0]       stall_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [7:0]       stall_q, stall_d;

  logic load_en;
  logic grant_vld;
  logic grant;

  always_comb begin
    load_en   = (state_q == StEmpty) || out_ready;
    grant_vld = load_en && (in1_valid || in2_valid);
    // Under contention the side that did not win last time goes first.
    grant     = (in1_valid && in2_valid) ? ~last_q : in2_valid;

    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    last_d     = last_q;
    sel_d      = sel_q;
    stall_d    = stall_q;

    if (grant_vld) begin
      state_d    = StFull;
      out_data_d = grant ? in2_data : in1_data;
      out_src_d  = grant;
      last_d     = grant;
      sel_d      = grant;
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end

    if (state_q == StFull && !out_ready && stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      out_src_q  <= 1'b0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      stall_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      stall_q    <= stall_d;
    end
  end

  // Reset overrides the combinational handshake so nothing is accepted during reset.
  assign sel       = reset ? 1'b0 : (grant_vld ? grant : sel_q);
  assign in1_ready = !reset && grant_vld && !grant;
  assign in2_ready = !reset && grant_vld && grant;
  assign out_valid = (state_q == StFull);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cdb_arb_2x1.sv
// Scoreboard bench for cdb_arb_2x1: a driver issues random and directed traffic against
// a transaction-level model; a negedge monitor checks every bus transfer against a queue.
module tb_cdb_arb_2x1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in1_valid = 1'b0, in2_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in1_data = '0, in2_data = '0;
  logic       in1_ready, in2_ready, out_valid, sel, out_src;
  logic [7:0] out_data, stall_cnt;

  always #5 clk = ~clk;

  cdb_arb_2x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .out_src   (out_src),
    .stall_cnt (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: slot occupancy, who won last, held payload and stall count.
  bit       m_full = 0;
  int       m_last = 2;
  int       m_sel = 1;
  bit [7:0] m_data = 0;
  bit       m_src = 0;
  int       m_stall = 0;
  bit [8:0] sb_q[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One bus cycle: check registered state, apply inputs, check handshake, advance model.
  task automatic cycle(input bit v1, input bit [7:0] d1, input bit v2, input bit [7:0] d2,
                       input bit ordy, input bit rst);
    int winner;
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(m_full));
    chk("out_data", int'(out_data), int'(m_data));
    chk("out_src", int'(out_src), int'(m_src));
    chk("stall_cnt", int'(stall_cnt), m_stall);
    reset = rst; in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2;
    out_ready = ordy;
    #1;
    if (rst) begin
      chk("rst_in1_ready", int'(in1_ready), 0);
      chk("rst_in2_ready", int'(in2_ready), 0);
      chk("rst_sel", int'(sel), 0);
      m_full = 0; m_last = 2; m_sel = 0; m_data = 0; m_src = 0; m_stall = 0;
      sb_q.delete();
      return;
    end
    winner = 0;
    if (!m_full || ordy) begin
      if (v1 && v2) winner = (m_last == 2) ? 1 : 2;
      else if (v1)  winner = 1;
      else if (v2)  winner = 2;
    end
    chk("in1_ready", int'(in1_ready), int'(winner == 1));
    chk("in2_ready", int'(in2_ready), int'(winner == 2));
    if (winner != 0) m_sel = winner - 1;
    chk("sel", int'(sel), m_sel);
    if (m_full && !ordy && m_stall < 255) m_stall++;
    if (winner != 0) begin
      m_last = winner;
      m_data = (winner == 1) ? d1 : d2;
      m_src  = (winner == 2);
      m_full = 1;
      sb_q.push_back({m_src, m_data});
    end else if (m_full && ordy) begin
      m_full = 0;
    end
  endtask

  // Monitor: each consumed payload must be the oldest one the model granted.
  always @(negedge clk) begin
    bit [8:0] exp;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: got data %0h with empty scoreboard", out_data);
      end else begin
        exp = sb_q.pop_front();
        chk("xfer_data", int'(out_data), int'(exp[7:0]));
        chk("xfer_src", int'(out_src), int'(exp[8]));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    cycle(0, 0, 0, 0, 0, 1);

    // Single request from in1.
    cycle(1, 8'hA5, 0, 8'h5A, 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 1, 0);
    chk("s1_data", int'(out_data), 8'hA5);

    // Contention with a consumer always ready: in1 first, then alternation.
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (5) cycle(1, 8'h11, 1, 8'h22, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Backpressure: hold 0x33 for five stalled cycles, then release.
    cycle(1, 8'h33, 0, 0, 1, 0);
    repeat (5) cycle(0, 0, 1, 8'h44, 0, 0);
    cycle(0, 0, 1, 8'h44, 1, 0);
    chk("s3_stall", int'(stall_cnt), 5);
    cycle(0, 0, 0, 0, 1, 0);

    // Saturation of the stall counter.
    cycle(1, 8'h55, 0, 0, 1, 0);
    repeat (300) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("s4_sat", int'(stall_cnt), 255);

    // Drain, then reset while full with both requesting.
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("s5_hold", int'(out_data), 8'h55);
    cycle(1, 8'h66, 1, 8'h77, 1, 0);
    cycle(1, 8'h66, 1, 8'h77, 0, 1);
    cycle(1, 8'h88, 1, 8'h99, 0, 0);
    chk("s6_first", int'(out_src), 0);

    // Random traffic with varied request and backpressure densities.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 60), 8'($urandom), ($urandom_range(99) < 60), 8'($urandom),
            ($urandom_range(99) < 70), ($urandom_range(999) < 5));
    end
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
